// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch block: FSM state, fetch granule,
// and the {pc, instr} record carried through the prefetch queue.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} records.
// Flush has priority over push and pop; pop of an empty queue is never requested.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the async ROM and
// buffers {pc, instr} for decode; a redirect flushes wrong-path entries.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic             enq;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    fetch_entry_t     q_head;
    fetch_entry_t     q_wr_entry;

    // A redirect hides the head so a coincident handshake is never consumed.
    assign instr_valid = !q_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign enq         = (state_q == RUN) && !redirect_valid && (!q_full || pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en && !redirect_valid) state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_valid) begin
            fpc_d = {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (enq) begin
            fpc_d = fpc_q + WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    assign q_wr_entry = '{pc: fpc_q, instr: rom_data};

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (enq),
        .push_entry (q_wr_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

    assign rom_addr = fpc_q;
    assign instr    = instr_valid ? q_head.instr : '0;
    assign instr_pc = instr_valid ? q_head.pc    : '0;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the asynchronous-read instruction ROM. It owns the fetch PC, drives the ROM byte address, and captures each returned word with its PC into a small prefetch queue. Decode consumes the queue through a valid/ready handshake. It sits between the instruction ROM and the decode stage; branch/jump resolution redirects it and flushes wrong-path instructions.

## Interface
Parameters:
- WIDTH, 32, instruction and address width
- RESET_PC, 32'h0000_0000, fetch PC after reset (byte address, word aligned)
- DEPTH, 2, prefetch queue entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  permits fetching
- rom_addr  out  WIDTH  byte address to the ROM; equals the fetch PC register
- rom_data  in  WIDTH  ROM read data, combinational from rom_addr
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  WIDTH  target byte address; bits [1:0] ignored (forced 0)
- instr_valid  out  1  queue head is valid
- instr_ready  in  1  decode accepts the head
- instr  out  WIDTH  head instruction word; 0 when !instr_valid
- instr_pc  out  WIDTH  head instruction's PC; 0 when !instr_valid

## Operation
- State machine (enum): IDLE, RUN. Reset → IDLE.
  - IDLE → RUN when fetch_en=1.
  - RUN → IDLE when fetch_en=0. The queue keeps draining in IDLE.
- Enqueue condition (call it enq): state==RUN && !redirect_valid && (count<DEPTH || pop).
- On enq: write {fpc, rom_data} at the tail, then fpc <= fpc + 4. Addition wraps modulo 2^WIDTH.
- pop = instr_valid && instr_ready && !redirect_valid.
- Redirect has priority over everything:
  - fpc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - count, rd_ptr and wr_ptr all <= 0.
  - No enqueue and no pop that cycle. A handshake coinciding with a redirect is discarded, not consumed.
  - A redirect in IDLE updates fpc and stays in IDLE.
- Full queue and pop in the same cycle: enqueue is allowed and count is unchanged.
- Empty queue: instr_valid=0.
- instr_valid = (count!=0) && !redirect_valid.
- rst overrides all inputs, including in mid-run and mid-redirect.

## Timing
Reset values:
- fpc = RESET_PC
- rom_addr = RESET_PC
- state = IDLE
- count and pointers = 0
- instr_valid = 0, instr = 0, instr_pc = 0

Latencies:
- rst released with fetch_en=1: RUN in cycle 1, first enqueue at the cycle-1 edge, instr_valid=1 in cycle 2 with instr_pc=RESET_PC.
- Redirect in cycle N: first enqueue in N+1, instr_valid=1 in N+2 with instr_pc equal to the target.

Throughput and stalls:
- Throughput is 1 instruction/cycle while instr_ready=1 and fetch_en=1.
- With instr_ready held 0, the queue fills after DEPTH enqueues. fpc then holds, pointing at the next unfetched word.
- instr, instr_pc and instr_valid are stable while instr_valid=1 and instr_ready=0, absent a redirect.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN}
  - INSTR_BYTES = 4
  - fetch_entry_t packed struct {pc, instr}
- Sub-module fetch_queue:
  - synchronous FIFO of fetch_entry_t, DEPTH entries
  - ports: push, pop, flush, full, empty, head
  - flush has priority over push and pop
- fetch_ctrl holds the FSM, fpc, the enqueue/pop logic, and output zeroing.

## Test plan
- Reset with fetch_en=1, instr_ready=1, ROM word i = 0x1000+i → one per cycle: instr_pc 0x0, 0x4, 0x8… with instr 0x1000, 0x1001, 0x1002…; first valid in cycle 2.
- instr_ready=0 for 6 cycles → exactly 2 entries buffered, rom_addr holds 0x8, head remains pc=0x0. Then ready=1 → 0x0, 0x4, 0x8 in consecutive cycles, no gap or duplicate.
- Redirect to 0x43 while instr_valid=1 and instr_ready=1 → that head is not consumed; instr_valid=0 next cycle; pc=0x40 valid two cycles after the redirect.
- fpc=0xFFFF_FFFC via redirect → next fetched pc wraps to 0x0000_0000.
- fetch_en dropped with 2 entries queued → both drain, then instr_valid=0 and rom_addr frozen. Reasserting resumes from the frozen address.
- rst asserted mid-stream with a redirect pending → next cycle: IDLE, instr_valid=0, rom_addr=RESET_PC.
